// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory port arbiter.
//   - arb_state_t : FSM encoding (IDLE / DATA / INST), 2 bits
//   - STALL_ENABLE / STALL_DISABLE : stall levels, same sense as the
//     pipeline pause constants they are ORed into
//   - default bus widths and timeout limit
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_DATA = 2'd1,
    ARB_INST = 2'd2
  } arb_state_t;

  localparam logic STALL_ENABLE  = 1'b1;
  localparam logic STALL_DISABLE = 1'b0;

  localparam int ARB_ADDR_W  = 32;
  localparam int ARB_DATA_W  = 32;
  localparam int ARB_TIMEOUT = 255;

endpackage

// File: rtl/mem_port_arbiter_timeout_cnt.sv
// Access watchdog for the memory port arbiter.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   clr       - return the count to zero (takes priority over en)
//   en        - count one waiting cycle
//   hit       - count has reached TIMEOUT
// The count saturates at TIMEOUT so hit stays asserted until cleared.
module arb_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= 8'd0;
    end else if (en && (cnt != LIMIT)) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign hit = (cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port RAM between the IF stage (fetch, read-only)
// and the MEM stage (load/store). MEM wins a simultaneous request, but
// the FSM never re-enters the state it just left, so each requester gets
// a turn after the other has been served.
//
// Handshake: a requester raises req with stable qualifiers and keeps them
// until its stall drops; the cycle where req=1 and stall=0 is completion
// and the pipeline advances on that edge. Towards the RAM, ram_req and
// the ram_* fields are registered and held until a one-cycle ram_ack
// (ram_rdata valid with it) or a watchdog timeout ends the access.
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   if_req/if_addr               fetch request;  if_rdata, if_stall back
//   mem_req/we/addr/wdata/be     data request;   mem_rdata, mem_stall back
//   ram_req/we/addr/wdata/be     registered RAM command
//   ram_ack/ram_rdata            RAM completion strobe and read data
//   bus_err                      one-cycle pulse when an access times out
//   dbg_state                    current FSM state
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ARB_ADDR_W,
  parameter int DATA_W  = ARB_DATA_W,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_stall,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_stall,
  output logic                ram_req,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [DATA_W/8-1:0] ram_be,
  input  logic                ram_ack,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic                bus_err,
  output logic [1:0]          dbg_state
);

  arb_state_t state, state_nxt;

  logic busy;
  logic hit;
  logic timed_out;
  logic done;

  assign busy      = (state == ARB_DATA) || (state == ARB_INST);
  // An ack in the limit cycle wins over the timeout.
  assign timed_out = busy && hit && !ram_ack;
  assign done      = busy && (ram_ack || hit);
  assign bus_err   = timed_out;
  assign dbg_state = state;

  // Cleared while idle and on every completion, so each grant starts at 0.
  arb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk (clk),
    .rst (rst),
    .clr (!busy || done),
    .en  (busy && !ram_ack),
    .hit (hit)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (mem_req)     state_nxt = ARB_DATA;
        else if (if_req) state_nxt = ARB_INST;
      end
      ARB_DATA: begin
        if (done) state_nxt = if_req ? ARB_INST : ARB_IDLE;
      end
      ARB_INST: begin
        // The if_req seen here is the fetch just served, so never INST again.
        if (done) state_nxt = mem_req ? ARB_DATA : ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    mem_stall = STALL_DISABLE;
    if_stall  = STALL_DISABLE;
    if (mem_req && !((state == ARB_DATA) && done)) mem_stall = STALL_ENABLE;
    if (if_req  && !((state == ARB_INST) && done)) if_stall  = STALL_ENABLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ARB_IDLE;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_be    <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ARB_IDLE: begin
          if (mem_req) begin
            ram_req   <= 1'b1;
            ram_we    <= mem_we;
            ram_addr  <= mem_addr;
            ram_wdata <= mem_wdata;
            ram_be    <= mem_be;
          end else if (if_req) begin
            ram_req   <= 1'b1;
            ram_we    <= 1'b0;
            ram_addr  <= if_addr;
            ram_wdata <= '0;
            ram_be    <= '1;
          end
        end
        ARB_DATA: begin
          if (done) begin
            if (timed_out)    mem_rdata <= '0;
            else if (!ram_we) mem_rdata <= ram_rdata;
            if (if_req) begin
              ram_req   <= 1'b1;
              ram_we    <= 1'b0;
              ram_addr  <= if_addr;
              ram_wdata <= '0;
              ram_be    <= '1;
            end else begin
              ram_req   <= 1'b0;
            end
          end
        end
        ARB_INST: begin
          if (done) begin
            if_rdata <= timed_out ? '0 : ram_rdata;
            if (mem_req) begin
              ram_req   <= 1'b1;
              ram_we    <= mem_we;
              ram_addr  <= mem_addr;
              ram_wdata <= mem_wdata;
              ram_be    <= mem_be;
            end else begin
              ram_req   <= 1'b0;
            end
          end
        end
        default: ram_req <= 1'b0;
      endcase
    end
  end

endmodule
